mpu_host_cmd_seq: RTL

// - Host-side initiator for the MPU external command interface. Turns one host command
//   (RUN/ST_PROG/ST_DATA/LD_DATA/STOP/SET_EN) into the MPU beat sequence.
// - Streams write payload out, collects load payload back, watches MPU state[3:0] for completion.
// - Sits between host/testbench DMA and the MPU top; drives mpu_in_t, consumes mpu_out_t.

---
 rtl/mpu_host_cmd_seq_pkg.sv | 83 ++++++++
 rtl/mpu_hseq_timer.sv | 37 +++
 rtl/mpu_host_cmd_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mpu_host_cmd_seq_pkg.sv
// Shared types for the MPU host command sequencer: beat structs, host opcodes,
// FSM states, error codes and the bit positions used in the MPU state/command words.
package mpu_host_cmd_seq_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic  v;
        data_t instr;
        data_t data;
    } mpu_in_t;

    typedef struct packed {
        logic  v;
        data_t data;
    } mpu_out_t;

    typedef enum logic [2:0] {
        HCMD_RUN     = 3'd0,
        HCMD_ST_PROG = 3'd1,
        HCMD_ST_DATA = 3'd2,
        HCMD_LD_DATA = 3'd3,
        HCMD_STOP    = 3'd4,
        HCMD_SET_EN  = 3'd5,
        HCMD_RSVD6   = 3'd6,
        HCMD_RSVD7   = 3'd7
    } hcmd_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAKE,
        S_CMD,
        S_OPND_ID,
        S_OPND_STRIDE,
        S_OPND_BASE,
        S_PAYLOAD,
        S_RECV,
        S_WAIT,
        S_FIN
    } fsm_hseq_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_NOTHMEM = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    // MPU state word bit positions
    localparam int STATE_READY   = 0;
    localparam int STATE_RUN     = 1;
    localparam int STATE_STOP    = 2;
    localparam int STATE_NOTHMEM = 3;

    localparam int CMD_BIT_RUN     = 0;
    localparam int CMD_BIT_ST_PROG = 1;
    localparam int CMD_BIT_ST_DATA = 2;
    localparam int CMD_BIT_LD_DATA = 3;
    localparam int CMD_BIT_STOP    = 4;
    localparam int CMD_BIT_SET_EN  = 5;

    function automatic data_t cmd_onehot(input hcmd_t op);
        data_t r;
        r = '0;
        case (op)
            HCMD_RUN:     r[CMD_BIT_RUN]     = 1'b1;
            HCMD_ST_PROG: r[CMD_BIT_ST_PROG] = 1'b1;
            HCMD_ST_DATA: r[CMD_BIT_ST_DATA] = 1'b1;
            HCMD_LD_DATA: r[CMD_BIT_LD_DATA] = 1'b1;
            HCMD_STOP:    r[CMD_BIT_STOP]    = 1'b1;
            HCMD_SET_EN:  r[CMD_BIT_SET_EN]  = 1'b1;
            default:      r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_legal(input hcmd_t op);
        return (op <= HCMD_SET_EN);
    endfunction

endpackage

// File: rtl/mpu_hseq_timer.sv
// Elapsed-cycle counter for the command sequencer; expired fires on the enabled
// cycle whose increment would bring the count to TIMEOUT-1.
module mpu_hseq_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Independent of clr so the FSM can use it without a combinational loop
    assign expired = en && (count_q == CW'(TIMEOUT - 2));

endmodule

// File: rtl/mpu_host_cmd_seq.sv
// Host-side initiator: expands one host command into the MPU beat sequence,
// streams/collects payload and waits on the MPU state word for completion.
//   state         | meaning
//   S_IDLE        | ready for a host command
//   S_WAKE/S_CMD  | wake beat, then one-hot command beat
//   S_OPND_*      | operand beats (ID / stride / base)
//   S_PAYLOAD     | write beats, one per I_Wr_Valid
//   S_RECV        | collecting load return beats
//   S_WAIT        | waiting for the MPU completion bit
//   S_FIN         | one-cycle done/error pulse
module mpu_host_cmd_seq
    import mpu_host_cmd_seq_pkg::*;
#(
    parameter int WIDTH_DATA = DATA_W,
    parameter int WIDTH_LEN  = 16,
    parameter int NUM_TPU    = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Cmd_Valid,
    output logic                  O_Cmd_Ready,
    input  logic [2:0]            I_Cmd_Op,
    input  logic [WIDTH_DATA-1:0] I_Cmd_ID,
    input  logic [WIDTH_DATA-1:0] I_Cmd_Stride,
    input  logic [WIDTH_DATA-1:0] I_Cmd_Base,
    input  logic [WIDTH_LEN-1:0]  I_Cmd_Len,
    input  logic                  I_Wr_Valid,
    input  logic [WIDTH_DATA-1:0] I_Wr_Data,
    output logic                  O_Wr_Ready,
    output logic                  O_Rd_Valid,
    output logic [WIDTH_DATA-1:0] O_Rd_Data,
    output logic                  O_Req_IF,
    output mpu_in_t               O_Data_IF,
    input  mpu_out_t              I_Data_IF,
    input  logic [3:0]            I_State,
    output logic                  O_Busy,
    output logic                  O_Done,
    output logic                  O_Err,
    output logic [1:0]            O_Err_Code
);

    fsm_hseq_t             state_q, state_d;
    hcmd_t                 op_q, op_d;
    logic [WIDTH_DATA-1:0] id_q, id_d;
    logic [WIDTH_DATA-1:0] stride_q, stride_d;
    logic [WIDTH_DATA-1:0] base_q, base_d;
    logic [WIDTH_LEN-1:0]  len_q, len_d;
    err_code_t             err_code_q, err_code_d;

    logic tmr_clr, tmr_en, tmr_expired;
    logic wait_done;

    mpu_hseq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        wait_done = 1'b0;
        case (op_q)
            HCMD_RUN:  wait_done = I_State[STATE_RUN];
            HCMD_STOP: wait_done = I_State[STATE_STOP];
            default:   wait_done = I_State[STATE_READY];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        id_d        = id_q;
        stride_d    = stride_q;
        base_d      = base_q;
        len_d       = len_q;
        err_code_d  = err_code_q;
        O_Cmd_Ready = 1'b0;
        O_Req_IF    = 1'b0;
        O_Data_IF   = '0;
        O_Wr_Ready  = 1'b0;
        O_Rd_Valid  = 1'b0;
        O_Rd_Data   = '0;
        O_Done      = 1'b0;
        O_Err       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                O_Cmd_Ready = 1'b1;
                if (I_Cmd_Valid) begin
                    op_d     = hcmd_t'(I_Cmd_Op);
                    id_d     = I_Cmd_ID;
                    stride_d = I_Cmd_Stride;
                    base_d   = I_Cmd_Base;
                    len_d    = I_Cmd_Len;
                    if (is_legal(hcmd_t'(I_Cmd_Op))) begin
                        err_code_d = ERR_NONE;
                        state_d    = S_WAKE;
                    end else begin
                        err_code_d = ERR_ILLEGAL;
                        state_d    = S_FIN;
                    end
                end
            end
            S_WAKE: begin
                O_Req_IF = 1'b1;
                state_d  = S_CMD;
            end
            S_CMD: begin
                O_Req_IF       = 1'b1;
                O_Data_IF.data = cmd_onehot(op_q);
                case (op_q)
                    HCMD_ST_PROG: state_d = (len_q == '0) ? S_WAIT : S_PAYLOAD;
                    HCMD_STOP:    state_d = S_WAIT;
                    default:      state_d = S_OPND_ID;
                endcase
            end
            S_OPND_ID: begin
                O_Req_IF = 1'b1;
                if (op_q == HCMD_SET_EN) begin
                    O_Data_IF.data[NUM_TPU-1:0] = id_q[NUM_TPU-1:0];
                    state_d = S_FIN;
                end else begin
                    O_Data_IF.data = id_q;
                    state_d = (op_q == HCMD_RUN) ? S_WAIT : S_OPND_STRIDE;
                end
            end
            S_OPND_STRIDE: begin
                O_Req_IF       = 1'b1;
                O_Data_IF.data = stride_q;
                state_d        = S_OPND_BASE;
            end
            S_OPND_BASE: begin
                O_Req_IF       = 1'b1;
                O_Data_IF.data = base_q;
                if (len_q == '0) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = (op_q == HCMD_LD_DATA) ? S_RECV : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (I_Wr_Valid) begin
                    O_Req_IF   = 1'b1;
                    O_Wr_Ready = 1'b1;
                    if (op_q == HCMD_ST_PROG) begin
                        O_Data_IF.v     = 1'b1;
                        O_Data_IF.instr = I_Wr_Data;
                    end else begin
                        O_Data_IF.data  = I_Wr_Data;
                    end
                    len_d = len_q - WIDTH_LEN'(1);
                    if (len_q == WIDTH_LEN'(1)) begin
                        state_d = S_WAIT;
                    end
                end else if (tmr_expired) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_FIN;
                end
            end
            S_RECV: begin
                if (I_Data_IF.v) begin
                    O_Rd_Valid = 1'b1;
                    O_Rd_Data  = I_Data_IF.data;
                    len_d      = len_q - WIDTH_LEN'(1);
                    if (len_q == WIDTH_LEN'(1)) begin
                        state_d = S_WAIT;
                    end
                end else if (tmr_expired) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_FIN;
                end
            end
            S_WAIT: begin
                // NoThMem outranks a simultaneous completion bit
                if (I_State[STATE_NOTHMEM]) begin
                    err_code_d = ERR_NOTHMEM;
                    state_d    = S_FIN;
                end else if (wait_done) begin
                    state_d = S_FIN;
                end else if (tmr_expired) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_FIN;
                end
            end
            S_FIN: begin
                O_Done  = (err_code_q == ERR_NONE);
                O_Err   = (err_code_q != ERR_NONE);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tmr_en     = (state_q == S_PAYLOAD) || (state_q == S_RECV) || (state_q == S_WAIT);
    assign tmr_clr    = (state_d != state_q) || O_Req_IF || O_Rd_Valid;
    assign O_Busy     = (state_q != S_IDLE);
    assign O_Err_Code = err_code_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= HCMD_RUN;
            id_q       <= '0;
            stride_q   <= '0;
            base_q     <= '0;
            len_q      <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            id_q       <= id_d;
            stride_q   <= stride_d;
            base_q     <= base_d;
            len_q      <= len_d;
            err_code_q <= err_code_d;
        end
    end

endmodule
